// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC local endpoint: flit layout, TX FSM states,
// and a helper that packs a host request into a single-flit packet.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 8;
    localparam int DBG_CNT_W = 8;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
    } flit_t;

    typedef enum logic [0:0] {
        TX_IDLE        = 1'b0,
        TX_WAIT_CREDIT = 1'b1
    } ep_tx_state_t;

    function automatic flit_t make_flit(input logic [COORD_W-1:0]   x,
                                        input logic [COORD_W-1:0]   y,
                                        input logic [PAYLOAD_W-1:0] p);
        flit_t f;
        f.payload = p;
        f.dest_x  = x;
        f.dest_y  = y;
        return f;
    endfunction

endpackage

// File: rtl/noc_local_endpoint_if.sv
// Bundle of router-side, host-side and debug signals of the NoC local endpoint.
// The slave modport is the endpoint; the master modport is the router plus host around it.
interface noc_local_endpoint_if;
    import noc_pkg::*;

    // Host TX: a request transfers on a cycle where tx_valid_i && tx_ready_o; the host must
    // hold valid and fields stable until then. Host RX: rx_valid_o && rx_ready_i pops the head.
    // Router side has no backpressure: net_valid_* are single-cycle strobes governed by
    // one-cycle net_credit_* pulses, one credit per flit.
    logic [FLIT_W-1:0]    net_data_o;
    logic                 net_valid_o;
    logic                 net_credit_i;
    logic [FLIT_W-1:0]    net_data_i;
    logic                 net_valid_i;
    logic                 net_credit_o;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [COORD_W-1:0]   tx_dest_x_i;
    logic [COORD_W-1:0]   tx_dest_y_i;
    logic [PAYLOAD_W-1:0] tx_payload_i;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [PAYLOAD_W-1:0] rx_payload_o;
    logic                 err_o;
    ep_tx_state_t         tx_state_o;
    logic [DBG_CNT_W-1:0] credit_cnt_o;

    modport slave (
        output net_data_o, net_valid_o, net_credit_o,
        input  net_credit_i, net_data_i, net_valid_i,
        input  tx_valid_i, tx_dest_x_i, tx_dest_y_i, tx_payload_i,
        output tx_ready_o,
        output rx_valid_o, rx_payload_o,
        input  rx_ready_i,
        output err_o, tx_state_o, credit_cnt_o
    );

    modport master (
        input  net_data_o, net_valid_o, net_credit_o,
        output net_credit_i, net_data_i, net_valid_i,
        output tx_valid_i, tx_dest_x_i, tx_dest_y_i, tx_payload_i,
        input  tx_ready_o,
        input  rx_valid_o, rx_payload_o,
        output rx_ready_i,
        input  err_o, tx_state_o, credit_cnt_o
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module noc_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/noc_local_endpoint.sv
// Endpoint between a processing element and a router's local port: credit-controlled
// single-flit injection and buffered ejection. Optional macro: NOC_EP_DEST_CHECK_EN.
module noc_local_endpoint
    import noc_pkg::*;
#(
    parameter int XCOORD   = 1111,
    parameter int YCOORD   = 1111,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int CREDITS  = 4
) (
    input logic                 clk,
    input logic                 rst,
    noc_local_endpoint_if.slave bus
);

    localparam int              CW        = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]   CREDITS_C = CW'(CREDITS);
    localparam int              OW        = $clog2(RX_DEPTH + 3);

    // ---------------- TX path ----------------
    ep_tx_state_t          state_q, state_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  cred_ovf;
    logic [FLIT_W-1:0]     net_data_q;
    logic                  net_valid_q;
    logic                  tx_fire;
    logic                  tx_full, tx_empty;
    logic                  tx_push, tx_pop;
    logic                  have_req;
    logic                  send;
    flit_t                 req_flit, tx_head, send_flit;
    logic [FLIT_W-1:0]     tx_head_raw;

    assign bus.tx_ready_o = !tx_full;
    assign tx_fire        = bus.tx_valid_i && !tx_full;
    assign req_flit       = make_flit(bus.tx_dest_x_i, bus.tx_dest_y_i, bus.tx_payload_i);
    assign tx_head        = flit_t'(tx_head_raw);
    assign have_req       = !tx_empty || tx_fire;

    // An empty FIFO lets a fresh request go straight to the output register,
    // giving one-cycle push-to-strobe latency; otherwise the head goes first.
    assign send_flit = tx_empty ? req_flit : tx_head;
    assign tx_pop    = send && !tx_empty;
    assign tx_push   = tx_fire && !(send && tx_empty);

    noc_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .data_i  (req_flit),
        .pop_i   (tx_pop),
        .data_o  (tx_head_raw),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= TX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:        if (have_req && credit_q == '0) state_d = TX_WAIT_CREDIT;
            TX_WAIT_CREDIT: if (send) state_d = TX_IDLE;
            default:        state_d = TX_IDLE;
        endcase
    end

    // A credit arriving while waiting is spent immediately on the head flit.
    always_comb begin
        send = 1'b0;
        case (state_q)
            TX_IDLE:        send = have_req && (credit_q != '0);
            TX_WAIT_CREDIT: send = !tx_empty && ((credit_q != '0) || bus.net_credit_i);
            default:        send = 1'b0;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        cred_ovf = 1'b0;
        case ({send, bus.net_credit_i})
            2'b10:   credit_d = credit_q - {{(CW-1){1'b0}}, 1'b1};
            2'b01: begin
                if (credit_q == CREDITS_C) cred_ovf = 1'b1;
                else                       credit_d = credit_q + {{(CW-1){1'b0}}, 1'b1};
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q    <= CREDITS_C;
            net_valid_q <= 1'b0;
            net_data_q  <= '0;
        end else begin
            credit_q    <= credit_d;
            net_valid_q <= send;
            if (send) net_data_q <= send_flit;
        end
    end

    assign bus.net_valid_o  = net_valid_q;
    assign bus.net_data_o   = net_data_q;
    assign bus.tx_state_o   = state_q;
    assign bus.credit_cnt_o = DBG_CNT_W'(credit_q);

    // ---------------- RX path ----------------
    logic                 dest_ok;
    logic                 rx_wr, rx_pop, rx_ovf, rx_drop;
    logic                 rx_full, rx_empty;
    logic [PAYLOAD_W-1:0] rx_head;
    logic [OW-1:0]        owed_q, owed_d, owed_now;
    logic                 net_credit_q, net_credit_d;
    logic                 err_q, err_d;

`ifdef NOC_EP_DEST_CHECK_EN
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(XCOORD);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(YCOORD);
    flit_t rx_flit;
    assign rx_flit = flit_t'(bus.net_data_i);
    assign dest_ok = (rx_flit.dest_x == MY_X) && (rx_flit.dest_y == MY_Y);
`else
    assign dest_ok = 1'b1;
`endif

    assign rx_wr   = bus.net_valid_i && dest_ok;
    assign rx_drop = bus.net_valid_i && !dest_ok;
    assign rx_pop  = !rx_empty && bus.rx_ready_i;
    assign rx_ovf  = rx_wr && rx_full && !rx_pop;

    // Destination coordinates are already resolved on arrival, so only the payload is kept.
    noc_sync_fifo #(.WIDTH(PAYLOAD_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_wr),
        .data_i  (bus.net_data_i[FLIT_W-1:FLIT_W-PAYLOAD_W]),
        .pop_i   (rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // A pop and a misdirected-flit drop in one cycle owe two credits; the second
    // is carried over so every freed slot is eventually returned as one pulse.
    always_comb begin
        owed_now     = owed_q + OW'(rx_pop) + OW'(rx_drop);
        net_credit_d = (owed_now != '0);
        owed_d       = owed_now - OW'(net_credit_d);
        err_d        = err_q | cred_ovf | rx_ovf | rx_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owed_q       <= '0;
            net_credit_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            owed_q       <= owed_d;
            net_credit_q <= net_credit_d;
            err_q        <= err_d;
        end
    end

    assign bus.net_credit_o = net_credit_q;
    assign bus.rx_valid_o   = !rx_empty;
    assign bus.rx_payload_o = rx_empty ? '0 : rx_head;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Bench for noc_local_endpoint: directed scenarios plus randomized traffic, checked by a
// negedge monitor against a queue-based reference of flit order, RX occupancy and credits.
module tb_noc_local_endpoint;
  import noc_pkg::*;

  localparam int CREDITS  = 4;
  localparam int RX_DEPTH = 4;
  localparam int TX_DEPTH = 4;
  localparam int NODE_X   = 1;
  localparam int NODE_Y   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_local_endpoint_if bus();

  noc_local_endpoint #(
    .XCOORD(NODE_X), .YCOORD(NODE_Y), .TX_DEPTH(TX_DEPTH),
    .RX_DEPTH(RX_DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] tx_exp_q[$];
  logic [7:0]  rx_exp_q[$];
  int   outstanding = 0;
  int   tx_pulses = 0;
  int   rx_credit_pulses = 0;
  logic exp_err = 1'b0;
  logic ovf_pending = 1'b0;
  logic prev_credit_due = 1'b0;
  logic tx_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] flit_of(input int x, input int y, input int p);
    return 16'(p * 256 + x * 16 + y);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic pop_m;
    logic dok;
    logic drop;
    if (rst) begin
      tx_exp_q.delete();
      rx_exp_q.delete();
      exp_err = 1'b0;
      ovf_pending = 1'b0;
      prev_credit_due = 1'b0;
      outstanding = 0;
    end else begin
      check("err_o", bus.err_o, exp_err);
      check("net_credit_o", bus.net_credit_o, prev_credit_due);
      if (bus.net_credit_o) rx_credit_pulses++;
      if (bus.net_valid_o) begin
        tx_pulses++;
        outstanding++;
        check("tx_credit_bound", outstanding <= CREDITS, 1);
        if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got flit %h expected no flit at %0t", bus.net_data_o, $time);
        end else begin
          check("net_data_o", bus.net_data_o, tx_exp_q.pop_front());
        end
      end
      check("rx_valid_o", bus.rx_valid_o, rx_exp_q.size() > 0);
      pop_m = (rx_exp_q.size() > 0) && bus.rx_ready_i;
      if (pop_m) check("rx_payload_o", bus.rx_payload_o, rx_exp_q.pop_front());
`ifdef NOC_EP_DEST_CHECK_EN
      dok = (bus.net_data_i[7:4] == 4'(NODE_X)) && (bus.net_data_i[3:0] == 4'(NODE_Y));
`else
      dok = 1'b1;
`endif
      drop = 1'b0;
      if (bus.net_valid_i) begin
        if (!dok) begin
          drop = 1'b1;
          ovf_pending = 1'b1;
        end else if (rx_exp_q.size() < RX_DEPTH) begin
          rx_exp_q.push_back(bus.net_data_i[15:8]);
        end else begin
          ovf_pending = 1'b1;
        end
      end
      prev_credit_due = pop_m || drop;
      if (ovf_pending) begin
        exp_err = 1'b1;
        ovf_pending = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.tx_valid_i = 1'b0;
    bus.net_valid_i = 1'b0;
    bus.net_credit_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_tx(input int x, input int y, input int p);
    int waited;
    logic done;
    waited = 0;
    done = 1'b0;
    bus.tx_valid_i = 1'b1;
    bus.tx_dest_x_i = 4'(x);
    bus.tx_dest_y_i = 4'(y);
    bus.tx_payload_i = 8'(p);
    while (!done && waited <= 200) begin
      @(negedge clk);
      done = bus.tx_ready_o;
      cycle();
      waited++;
    end
    bus.tx_valid_i = 1'b0;
    if (done) tx_exp_q.push_back(flit_of(x, y, p));
    else check("tx_push_timeout", 0, 1);
  endtask

  task automatic credit_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.net_credit_i = 1'b1;
      if (outstanding > 0) outstanding--;
      else ovf_pending = 1'b1;
      cycle();
    end
    bus.net_credit_i = 1'b0;
  endtask

  task automatic rx_inject(input logic [15:0] f);
    bus.net_valid_i = 1'b1;
    bus.net_data_i = f;
    cycle();
    bus.net_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_net_valid"}, bus.net_valid_o, 0);
    check({tag, "_net_data"}, bus.net_data_o, 0);
    check({tag, "_net_credit"}, bus.net_credit_o, 0);
    check({tag, "_rx_valid"}, bus.rx_valid_o, 0);
    check({tag, "_rx_payload"}, bus.rx_payload_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
    check({tag, "_tx_ready"}, bus.tx_ready_o, 1);
    check({tag, "_state"}, bus.tx_state_o, TX_IDLE);
    check({tag, "_credits"}, bus.credit_cnt_o, CREDITS);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.tx_valid_i = 1'b0;
    bus.tx_dest_x_i = '0;
    bus.tx_dest_y_i = '0;
    bus.tx_payload_i = '0;
    bus.net_valid_i = 1'b0;
    bus.net_data_i = '0;
    bus.net_credit_i = 1'b0;
    bus.rx_ready_i = 1'b0;
    cycle();
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    cycle();

    // 1: single flit, one-cycle latency
    push_tx(2, 1, 8'hA5);
    @(negedge clk);
    check("t1_valid", bus.net_valid_o, 1);
    check("t1_data", bus.net_data_o, 16'hA521);
    cycle();
    @(negedge clk);
    check("t1_single_pulse", bus.net_valid_o, 0);
    cycle();
    credit_pulses(1);

    // 2: credit exhaustion and WAIT_CREDIT
    tx_pulses = 0;
    for (int i = 0; i < 6; i++) push_tx($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    repeat (6) cycle();
    check("t2_four_sends", tx_pulses, 4);
    check("t2_wait_state", bus.tx_state_o, TX_WAIT_CREDIT);
    credit_pulses(1);
    @(negedge clk);
    check("t2_fifth_next_cycle", bus.net_valid_o, 1);
    cycle();
    credit_pulses(4);
    repeat (3) cycle();
    credit_pulses(1);
    check("t2_drained", tx_exp_q.size(), 0);

    // 3: send and credit in the same cycle keeps the counter constant
    push_tx(3, 3, 8'h11);
    repeat (2) cycle();
    for (int i = 0; i < 8; i++) begin
      bus.tx_valid_i = 1'b1;
      bus.tx_dest_x_i = 4'($urandom_range(0, 15));
      bus.tx_dest_y_i = 4'($urandom_range(0, 15));
      bus.tx_payload_i = 8'($urandom_range(0, 255));
      bus.net_credit_i = 1'b1;
      outstanding--;
      @(negedge clk);
      check("t3_ready", bus.tx_ready_o, 1);
      check("t3_credits", bus.credit_cnt_o, CREDITS - 1);
      cycle();
      tx_exp_q.push_back(flit_of(bus.tx_dest_x_i, bus.tx_dest_y_i, bus.tx_payload_i));
    end
    bus.tx_valid_i = 1'b0;
    bus.net_credit_i = 1'b0;
    @(negedge clk);
    check("t3_credits_end", bus.credit_cnt_o, CREDITS - 1);
    check("t3_no_err", bus.err_o, 0);
    cycle();
    credit_pulses(1);

    // 4: RX fill, overflow, ordered drain with credit return
    rx_credit_pulses = 0;
    bus.rx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) rx_inject(flit_of(NODE_X, NODE_Y, $urandom_range(0, 255)));
    @(negedge clk);
    check("t4_rx_valid", bus.rx_valid_o, 1);
    check("t4_overflow_err", bus.err_o, 1);
    check("t4_no_credit_yet", rx_credit_pulses, 0);
    cycle();
    bus.rx_ready_i = 1'b1;
    repeat (8) cycle();
    check("t4_credit_pulses", rx_credit_pulses, 4);
    check("t4_drained", rx_exp_q.size(), 0);

    // credit overflow at full credits saturates and flags
    do_reset();
    credit_pulses(1);
    @(negedge clk);
    check("ovf_err", bus.err_o, 1);
    check("ovf_saturate", bus.credit_cnt_o, CREDITS);
    cycle();

`ifdef NOC_EP_DEST_CHECK_EN
    // 5: misdirected flit is dropped but its credit is returned
    do_reset();
    rx_credit_pulses = 0;
    rx_inject(16'h3322);
    repeat (3) cycle();
    check("t5_err", bus.err_o, 1);
    check("t5_credit", rx_credit_pulses, 1);
    check("t5_not_stored", bus.rx_valid_o, 0);
`endif

    // 6: reset with both FIFOs partly full
    do_reset();
    for (int i = 0; i < 6; i++) push_tx($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    bus.rx_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) rx_inject(flit_of(NODE_X, NODE_Y, $urandom_range(0, 255)));
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6");
    cycle();
    tx_pulses = 0;
    for (int i = 0; i < 4; i++) push_tx($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
    repeat (4) cycle();
    check("t6_four_sends", tx_pulses, 4);
    check("t6_tx_drained", tx_exp_q.size(), 0);

    // randomized traffic on both paths
    do_reset();
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) cycle();
          push_tx($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        tx_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (cyc < 3000 && (!tx_done || outstanding > 0 || tx_exp_q.size() > 0)) begin
          bus.net_credit_i = (outstanding > 0) && ($urandom_range(0, 2) == 0);
          if (bus.net_credit_i) outstanding--;
          cycle();
          cyc++;
        end
        bus.net_credit_i = 1'b0;
        if (cyc >= 3000) check("rand_tx_timeout", 0, 1);
      end
      begin
        for (int i = 0; i < 200; i++) begin
          bus.net_valid_i = ($urandom_range(0, 2) == 0);
          bus.net_data_i = flit_of(NODE_X, NODE_Y, $urandom_range(0, 255));
          bus.rx_ready_i = 1'($urandom_range(0, 1));
          cycle();
        end
        bus.net_valid_i = 1'b0;
        bus.rx_ready_i = 1'b1;
        repeat (10) cycle();
      end
    join
    repeat (4) cycle();
    check("rand_tx_drained", tx_exp_q.size(), 0);
    check("rand_rx_drained", rx_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
    $fatal(1);
  end

endmodule
